// File: rtl/merge16_serializer.sv
// Capture-and-drain output stage for the 8+8->16 merge network: latches the merged
// vector on cap and streams it over valid/ready. Define SORT_OUT_DESC_EN for descending order.
module merge16_serializer #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned n = 8,
  localparam int unsigned IW = $clog2(2*n)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*n*WIDTH-1:0]   inc,
  input  logic                   cap,
  output logic                   busy,
  output logic [WIDTH-1:0]       out_data,
  output logic [IW-1:0]          out_idx,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   done
);

  localparam int unsigned NE = 2*n;

`ifdef SORT_OUT_DESC_EN
  localparam logic [IW-1:0] START_IDX = IW'(NE-1);
  localparam logic [IW-1:0] END_IDX   = IW'(0);
`else
  localparam logic [IW-1:0] START_IDX = IW'(0);
  localparam logic [IW-1:0] END_IDX   = IW'(NE-1);
`endif

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] mem_q [NE];
  logic             load;
  logic             done_d;
  logic [WIDTH-1:0] data_d;

  // Next state; a capture may only land when idle or on the final transfer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    load    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cap) begin
          load    = 1'b1;
          ptr_d   = START_IDX;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (ptr_q == END_IDX) begin
            done_d = 1'b1;
            if (cap) begin
              load  = 1'b1;
              ptr_d = START_IDX;
            end else begin
              state_d = IDLE;
            end
          end else begin
`ifdef SORT_OUT_DESC_EN
            ptr_d = ptr_q - IW'(1);
`else
            ptr_d = ptr_q + IW'(1);
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Freshly captured data bypasses the buffer so element 0 appears one cycle after cap.
    data_d = load ? inc[int'(ptr_d) * int'(WIDTH) +: WIDTH] : mem_q[ptr_d];
  end

  // State, buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      for (int i = 0; i < int'(NE); i++) mem_q[i] <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (load) begin
        for (int i = 0; i < int'(NE); i++) mem_q[i] <= inc[i * int'(WIDTH) +: WIDTH];
      end
      out_valid <= (state_d == STREAM);
      busy      <= (state_d == STREAM);
      out_last  <= (state_d == STREAM) && (ptr_d == END_IDX);
      out_idx   <= ptr_d;
      out_data  <= data_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_merge16_serializer.sv
// Self-checking bench for merge16_serializer: directed table, hand-written corner
// sequences and a randomized run, all against a queue-based reference model.
module tb_merge16_serializer;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned N     = 8;
  localparam int unsigned NE    = 2*N;
  localparam int unsigned IW    = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NE*WIDTH-1:0]   inc;
  logic                  cap;
  logic                  busy;
  logic [WIDTH-1:0]      out_data;
  logic [IW-1:0]         out_idx;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  done;

  merge16_serializer #(.WIDTH(WIDTH), .n(N)) dut (
    .clk(clk), .rst(rst), .inc(inc), .cap(cap), .busy(busy),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference model: the elements still to be emitted, in emission order.
  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [IW-1:0]    i;
  } elem_t;
  elem_t m_q[$];
  logic  m_done = 1'b0;

  typedef struct {
    logic             cap;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [IW-1:0]    idx;
    logic             last;
    logic             done;
  } vec_t;
  vec_t vt[18];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  task automatic set_pattern();
    for (int k = 0; k < int'(NE); k++) inc[k*WIDTH +: WIDTH] = WIDTH'(k/2);
  endtask

  task automatic model_update(input logic c, input logic r, input logic rs);
    int idx;
    if (rs) begin
      m_q.delete();
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_q.size() > 0 && r) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_done = 1'b1;
      end
      if (c && m_q.size() == 0) begin
        for (int k = 0; k < int'(NE); k++) begin
`ifdef SORT_OUT_DESC_EN
          idx = int'(NE) - 1 - k;
`else
          idx = k;
`endif
          m_q.push_back('{d: inc[idx*WIDTH +: WIDTH], i: IW'(idx)});
        end
      end
    end
  endtask

  // Check current outputs against the model, then apply inputs across one edge.
  task automatic cycle(input logic c, input logic r, input logic rs);
    logic act;
    act = (m_q.size() > 0);
    chk("valid", out_valid, act);
    chk("busy", busy, act);
    chk("done", done, m_done);
    if (act) begin
      chk("data", out_data, m_q[0].d);
      chk("idx", out_idx, m_q[0].i);
      chk("last", out_last, (m_q.size() == 1));
    end
    cap = c; out_ready = r; rst = rs;
    @(posedge clk);
    model_update(c, r, rs);
    @(negedge clk);
  endtask

  initial begin
    int dcyc;
    int e;
    cap = 1'b0; out_ready = 1'b1; rst = 1'b1;
    set_pattern();

    // Reset then idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_data", out_data, 3'd0);
    chk("rst_idx", out_idx, 4'd0);
    chk("rst_last", out_last, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("idle_data", out_data, 3'd0);
    cycle(1'b0, 1'b1, 1'b0);

    // Directed table: full stream with ready held high.
    for (int i = 0; i < 18; i++) begin
`ifdef SORT_OUT_DESC_EN
      e = 16 - i;
`else
      e = i - 1;
`endif
      vt[i].cap   = (i == 0);
      vt[i].ready = 1'b1;
      vt[i].valid = (i >= 1 && i <= 16);
      vt[i].idx   = IW'(e);
      vt[i].data  = WIDTH'(e / 2);
      vt[i].last  = (i == 16);
      vt[i].done  = (i == 17);
    end
    for (int i = 0; i < 18; i++) begin
      chk("tbl_valid", out_valid, vt[i].valid);
      chk("tbl_done", done, vt[i].done);
      if (vt[i].valid) begin
        chk("tbl_data", out_data, vt[i].data);
        chk("tbl_idx", out_idx, vt[i].idx);
        chk("tbl_last", out_last, vt[i].last);
      end
      cycle(vt[i].cap, vt[i].ready, 1'b0);
    end

    // Backpressure in cycles 3..5 pushes done out to cycle 20.
    dcyc = -1;
    for (int i = 0; i < 24; i++) begin
      if (done === 1'b1 && dcyc < 0) dcyc = i;
      cycle(i == 0, !(i >= 3 && i <= 5), 1'b0);
    end
    chk("bp_done_cycle", 8'(dcyc), 8'd20);

    // Cap mid-stream with a different vector on inc is ignored.
    for (int i = 0; i < 19; i++) begin
      if (i == 5) inc = '1;
      cycle(i == 0 || i == 5, 1'b1, 1'b0);
      if (i == 5) set_pattern();
    end

    // Back-to-back capture on the final transfer, new vector all 5s.
    for (int i = 0; i < 35; i++) begin
      if (i == 16) for (int k = 0; k < int'(NE); k++) inc[k*WIDTH +: WIDTH] = 3'd5;
      cycle(i == 0 || i == 16, 1'b1, 1'b0);
      if (i == 16) chk("b2b_busy", busy, 1'b1);
    end
    chk("b2b_busy_hold", busy, 1'b0);
    set_pattern();

    // Reset mid-stream, then a clean restart.
    for (int i = 0; i < 12; i++) cycle(i == 0, 1'b1, i == 8);
    for (int i = 0; i < 19; i++) cycle(i == 0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      inc = (NE*WIDTH)'({$urandom(), $urandom()});
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0);
    end
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
